// File: rtl/nibble_tx_pkg.sv
// ---------------------------------------------------------------------------
// nibble_tx_pkg
// Shared definitions for the nibble UART transmitter and the bit timer.
// The receive side will reuse this package later.
//   - FSM state encoding (3-bit constants)
//   - frame geometry (FIFO word width, bits per frame)
//   - clog2 / counter width helpers for sizing counters from parameters
// ---------------------------------------------------------------------------
package nibble_tx_pkg;

  // FSM state encoding. Plain constants keep the encoding fixed for older
  // tools and for anyone probing the state register in a waveform.
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] START = 3'd3;
  localparam logic [2:0] DATA  = 3'd4;
  localparam logic [2:0] STOP  = 3'd5;

  // Width of the upstream 8x4 FIFO.
  localparam int FIFO_W = 4;

  // One start bit, FIFO_W data bits and one stop bit.
  localparam int FRAME_BITS = FIFO_W + 2;

  // Ceiling log2 of a positive value. clog2(1) is 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Counter width for a range of 'count' values. This is never narrower than
  // one bit, so a counter that only ever holds zero still has a real register.
  function automatic int counterWidth(input int count);
    int w;
    w = clog2(count);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// ---------------------------------------------------------------------------
// bit_timer
// Counts clock cycles within one serial bit period. It counts
// 0..CLKS_PER_BIT-1 while enabled and raises 'tick' during the final cycle of
// each bit. The count then wraps so that consecutive bits need no extra clear.
// With CLKS_PER_BIT=1 the count stays at zero and 'tick' follows 'en'.
//
// Ports:
//   clk_d  in  1  clock, rising edge
//   rst    in  1  asynchronous active-low reset
//   clr    in  1  synchronous clear of the count (has priority over en)
//   en     in  1  count enable
//   tick   out 1  high in the last cycle of a bit period while enabled
// ---------------------------------------------------------------------------
module bit_timer
  import nibble_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk_d,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = counterWidth(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_atLast;

  assign w_atLast = (r_count == LAST);
  assign tick     = en && w_atLast;

  // Cycle counter. It wraps on expiry, so the next bit period starts
  // immediately in the cycle after a tick.
  always_ff @(posedge clk_d or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= w_atLast ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/nibble_uart_tx.sv
// ---------------------------------------------------------------------------
// nibble_uart_tx
// Drains the 8x4 FIFO one word at a time and sends each word as a serial
// frame: a start bit (0), DATA_W data bits LSB first, and a stop bit (1).
// Each bit lasts CLKS_PER_BIT clocks. All outputs are decoded from registered
// state, so no input reaches an output combinationally.
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit, 1..256
//   DATA_W        word width, equal to the FIFO width
//
// Ports:
//   clk_d       in  1       system clock
//   rst         in  1       active-low reset. It asserts asynchronously and
//                           its release is synchronised to clk_d internally.
//   fifo_empty  in  1       FIFO empty flag
//   fifo_d_out  in  DATA_W  FIFO read data, valid the cycle after rd_req
//   rd_req      out 1       one-cycle FIFO read request
//   tx          out 1       serial line, idles high
//   busy        out 1       high whenever the FSM is not in IDLE
//   frame_done  out 1       one-cycle pulse in the last stop-bit cycle
// ---------------------------------------------------------------------------
module nibble_uart_tx
  import nibble_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  // The frame geometry in the package defines the FIFO width.
  parameter int DATA_W       = FRAME_BITS - 2
) (
  input  logic              clk_d,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_d_out,
  output logic              rd_req,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int IDX_W = counterWidth(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  logic              r_rstMeta;
  logic              r_rstSync;
  logic              w_rstN;

  logic [2:0]        r_state;
  logic [2:0]        w_nextState;
  logic [DATA_W-1:0] r_shreg;
  logic [IDX_W-1:0]  r_bitIdx;

  logic              w_timerClr;
  logic              w_timerEn;
  logic              w_tick;
  logic              w_lastBit;

  // Reset synchroniser. Its flops clear as soon as rst falls, so reset still
  // takes effect immediately. Release reaches the rest of the block only
  // after two clock edges, so no flop leaves reset close to a clock edge.
  always_ff @(posedge clk_d or negedge rst) begin
    if (!rst) begin
      r_rstMeta <= 1'b0;
      r_rstSync <= 1'b0;
    end else begin
      r_rstMeta <= 1'b1;
      r_rstSync <= r_rstMeta;
    end
  end

  assign w_rstN = r_rstSync;

  // The bit timer restarts in LOAD. It then runs through START, DATA and STOP
  // without further clears, because each tick wraps it back to zero.
  assign w_timerClr = (r_state == LOAD);
  assign w_timerEn  = (r_state == START) || (r_state == DATA) || (r_state == STOP);

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bitTimer (
    .clk_d (clk_d),
    .rst   (w_rstN),
    .clr   (w_timerClr),
    .en    (w_timerEn),
    .tick  (w_tick)
  );

  assign w_lastBit = (r_bitIdx == LAST_IDX);

  // Next-state logic. fifo_empty is looked at only in IDLE and at the end of
  // STOP. A flag that changes mid-frame therefore cannot cause a second read.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (!fifo_empty) w_nextState = REQ;
      REQ:     w_nextState = LOAD;
      LOAD:    w_nextState = START;
      START:   if (w_tick) w_nextState = DATA;
      DATA:    if (w_tick && w_lastBit) w_nextState = STOP;
      STOP:    if (w_tick) w_nextState = fifo_empty ? IDLE : REQ;
      default: w_nextState = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_d or negedge w_rstN) begin
    if (!w_rstN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Shift register and bit index. The word is captured in LOAD, which is the
  // cycle in which the FIFO presents the data requested in REQ. During DATA,
  // shreg[0] is always the bit on the line.
  always_ff @(posedge clk_d or negedge w_rstN) begin
    if (!w_rstN) begin
      r_shreg  <= '0;
      r_bitIdx <= '0;
    end else if (r_state == LOAD) begin
      r_shreg  <= fifo_d_out;
      r_bitIdx <= '0;
    end else if ((r_state == DATA) && w_tick) begin
      r_shreg  <= r_shreg >> 1;
      r_bitIdx <= r_bitIdx + 1'b1;
    end
  end

  // Moore outputs. REQ and LOAD keep the line high, which produces the
  // two-cycle gap between back-to-back frames.
  always_comb begin
    tx = 1'b1;
    case (r_state)
      START:   tx = 1'b0;
      DATA:    tx = r_shreg[0];
      default: tx = 1'b1;
    endcase
  end

  assign rd_req     = (r_state == REQ);
  assign busy       = (r_state != IDLE);
  assign frame_done = (r_state == STOP) && w_tick;

endmodule

// File: tb/tb_nibble_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_nibble_uart_tx
// Directed bench for nibble_uart_tx. Two instances run from one clock and
// reset: dutA with CLKS_PER_BIT=4 and dutB with CLKS_PER_BIT=1. Each instance
// has a small FIFO model that pops a word on rd_req and presents it on the
// following cycle. Every cycle the bench logs tx, rd_req and frame_done at the
// falling edge, then checks the logged waveforms against hand-computed frames.
// ---------------------------------------------------------------------------
module tb_nibble_uart_tx;

  logic       clk;
  logic       rstN;

  logic       aEmpty, aRdReq, aTx, aBusy, aDone;
  logic [3:0] aDout;
  logic       bEmpty, bRdReq, bTx, bBusy, bDone;
  logic [3:0] bDout;

  logic [3:0] aFifo[$];
  logic [3:0] bFifo[$];
  logic       aTxLog[$];
  logic       bTxLog[$];
  int         aRdLog[$];
  int         bRdLog[$];
  int         aDoneLog[$];
  int         bDoneLog[$];

  int         cycleNo;
  int         vectors;
  int         miscompares;

  nibble_uart_tx #(
    .CLKS_PER_BIT (4),
    .DATA_W       (4)
  ) dutA (
    .clk_d      (clk),
    .rst        (rstN),
    .fifo_empty (aEmpty),
    .fifo_d_out (aDout),
    .rd_req     (aRdReq),
    .tx         (aTx),
    .busy       (aBusy),
    .frame_done (aDone)
  );

  nibble_uart_tx #(
    .CLKS_PER_BIT (1),
    .DATA_W       (4)
  ) dutB (
    .clk_d      (clk),
    .rst        (rstN),
    .fifo_empty (bEmpty),
    .fifo_d_out (bDout),
    .rd_req     (bRdReq),
    .tx         (bTx),
    .busy       (bBusy),
    .frame_done (bDone)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single point of comparison: count it, and report a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors = vectors + 1;
    if (observed !== expected) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Queue a word into one FIFO model. After this, the FIFO is not empty.
  task automatic applyStimulus(input bit useB, input logic [3:0] word);
    if (useB) begin
      bFifo.push_back(word);
      bEmpty = 1'b0;
    end else begin
      aFifo.push_back(word);
      aEmpty = 1'b0;
    end
  endtask

  // Advance one cycle: sample at the falling edge, log the outputs, and let
  // the FIFO models answer read requests. The logged index is cycleNo.
  task automatic stepCycle();
    @(negedge clk);
    aTxLog.push_back(aTx);
    bTxLog.push_back(bTx);
    if (aDone === 1'b1) aDoneLog.push_back(cycleNo);
    if (bDone === 1'b1) bDoneLog.push_back(cycleNo);
    if (aRdReq === 1'b1) begin
      aRdLog.push_back(cycleNo);
      if (aFifo.size() == 0) begin
        checkOutput("A rd_req on empty FIFO", 32'd1, 32'd0);
      end else begin
        aDout  = aFifo.pop_front();
        aEmpty = (aFifo.size() == 0);
      end
    end
    if (bRdReq === 1'b1) begin
      bRdLog.push_back(cycleNo);
      if (bFifo.size() == 0) begin
        checkOutput("B rd_req on empty FIFO", 32'd1, 32'd0);
      end else begin
        bDout  = bFifo.pop_front();
        bEmpty = (bFifo.size() == 0);
      end
    end
    cycleNo = cycleNo + 1;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  // Pack 'len' logged tx samples starting at 'start'. Bit i of the result is
  // the sample at cycle start+i.
  function automatic logic [31:0] grabWave(input bit useB, input int start, input int len);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < len; i++) begin
      w[i] = useB ? bTxLog[start + i] : aTxLog[start + i];
    end
    return w;
  endfunction

  // Reference frame: start 0, data LSB first, stop 1, each bit repeated cpb times.
  function automatic logic [31:0] expWave(input logic [3:0] word, input int cpb);
    logic [31:0] w;
    logic        b;
    w = '0;
    for (int slot = 0; slot < 6; slot++) begin
      if (slot == 0)      b = 1'b0;
      else if (slot == 5) b = 1'b1;
      else                b = word[slot - 1];
      for (int c = 0; c < cpb; c++) w[slot * cpb + c] = b;
    end
    return w;
  endfunction

  initial begin
    int k;
    int rdBase;
    int doneBase;
    int badA;
    int badB;
    int i;

    vectors     = 0;
    miscompares = 0;
    cycleNo     = 0;
    aEmpty = 1'b1; aDout = 4'h0;
    bEmpty = 1'b1; bDout = 4'h0;
    rstN   = 1'b1;
    #2 rstN = 1'b0;

    // Reset state.
    runCycles(3);
    checkOutput("reset A tx", aTx, 1);
    checkOutput("reset A busy", aBusy, 0);
    checkOutput("reset A rd_req", aRdReq, 0);
    checkOutput("reset A frame_done", aDone, 0);
    checkOutput("reset B tx", bTx, 1);
    checkOutput("reset B busy", bBusy, 0);
    rstN = 1'b1;
    runCycles(4);

    // Idle with an empty FIFO for 100 cycles.
    badA = 0;
    badB = 0;
    for (i = 0; i < 100; i++) begin
      stepCycle();
      if (aTx !== 1'b1 || aBusy !== 1'b0 || aRdReq !== 1'b0) badA = badA + 1;
      if (bTx !== 1'b1 || bBusy !== 1'b0 || bRdReq !== 1'b0) badB = badB + 1;
    end
    checkOutput("idle A bad cycles", badA, 0);
    checkOutput("idle B bad cycles", badB, 0);

    // Single word 1011 at 4 clocks per bit: tx is 0,1,1,0,1,1 for 4 cycles each.
    rdBase = aRdLog.size(); doneBase = aDoneLog.size();
    applyStimulus(1'b0, 4'b1011);
    k = cycleNo - 1;
    runCycles(40);
    checkOutput("single rd_req count", aRdLog.size() - rdBase, 1);
    checkOutput("single rd_req cycle", aRdLog[rdBase] - k, 1);
    checkOutput("single gap before start", aTxLog[k + 2], 1);
    checkOutput("single frame wave", grabWave(1'b0, k + 3, 24), 32'h00FF0FF0);
    checkOutput("single line high after", aTxLog[k + 27], 1);
    checkOutput("single done count", aDoneLog.size() - doneBase, 1);
    checkOutput("single done latency", aDoneLog[doneBase] - k, 26);
    checkOutput("single busy after", aBusy, 0);

    // Eight back-to-back words 1..8: 26-cycle period, then idle.
    rdBase = aRdLog.size(); doneBase = aDoneLog.size();
    for (i = 1; i <= 8; i++) applyStimulus(1'b0, 4'(i));
    k = cycleNo - 1;
    runCycles(8 * 26 + 12);
    checkOutput("burst rd_req count", aRdLog.size() - rdBase, 8);
    checkOutput("burst done count", aDoneLog.size() - doneBase, 8);
    for (i = 0; i < 8; i++) begin
      checkOutput($sformatf("burst rd_req cycle %0d", i), aRdLog[rdBase + i] - k, 1 + 26 * i);
      checkOutput($sformatf("burst done cycle %0d", i), aDoneLog[doneBase + i] - k, 26 + 26 * i);
      checkOutput($sformatf("burst frame %0d", i), grabWave(1'b0, k + 3 + 26 * i, 24),
                  expWave(4'(i + 1), 4));
    end
    checkOutput("burst idle at end", aBusy, 0);

    // Reset in the middle of DATA: outputs return to idle at once and no
    // frame_done appears.
    doneBase = aDoneLog.size();
    applyStimulus(1'b0, 4'h5);
    k = cycleNo - 1;
    runCycles(12);
    checkOutput("pre-reset in DATA busy", aBusy, 1);
    rstN = 1'b0;
    #1;
    checkOutput("mid-frame reset tx", aTx, 1);
    checkOutput("mid-frame reset busy", aBusy, 0);
    checkOutput("mid-frame reset done", aDone, 0);
    runCycles(3);
    rstN = 1'b1;
    runCycles(20);
    checkOutput("no done after reset", aDoneLog.size() - doneBase, 0);

    // The next word after reset goes out intact: 1010 -> 0,0,1,0,1,1.
    doneBase = aDoneLog.size();
    applyStimulus(1'b0, 4'b1010);
    k = cycleNo - 1;
    runCycles(34);
    checkOutput("post-reset frame wave", grabWave(1'b0, k + 3, 24), 32'h00FF0F00);
    checkOutput("post-reset done latency", aDoneLog[doneBase] - k, 26);

    // fifo_empty toggling through START/DATA is ignored. 0011 -> 0,1,1,0,0,1.
    rdBase = aRdLog.size(); doneBase = aDoneLog.size();
    applyStimulus(1'b0, 4'b0011);
    k = cycleNo - 1;
    runCycles(2);
    for (i = 3; i <= 22; i++) begin
      stepCycle();
      aEmpty = (i == 22) ? 1'b1 : ~aEmpty;
    end
    runCycles(14);
    checkOutput("glitch rd_req count", aRdLog.size() - rdBase, 1);
    checkOutput("glitch frame wave", grabWave(1'b0, k + 3, 24), 32'h00F00FF0);
    checkOutput("glitch done count", aDoneLog.size() - doneBase, 1);
    checkOutput("glitch idle at end", aBusy, 0);

    // CLKS_PER_BIT=1, words 0110 then 1001 back to back, 8-cycle period.
    rdBase = bRdLog.size(); doneBase = bDoneLog.size();
    applyStimulus(1'b1, 4'b0110);
    applyStimulus(1'b1, 4'b1001);
    k = cycleNo - 1;
    runCycles(24);
    checkOutput("cpb1 first frame plus gap", grabWave(1'b1, k + 3, 8), 32'h000000EC);
    checkOutput("cpb1 second frame", grabWave(1'b1, k + 11, 6), 32'h00000032);
    checkOutput("cpb1 rd_req count", bRdLog.size() - rdBase, 2);
    checkOutput("cpb1 done count", bDoneLog.size() - doneBase, 2);
    checkOutput("cpb1 first done", bDoneLog[doneBase] - k, 8);
    checkOutput("cpb1 second done", bDoneLog[doneBase + 1] - k, 16);
    checkOutput("cpb1 idle at end", bBusy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nibble_uart_tx.md
# nibble_uart_tx

Downstream consumer of the 8x4 FIFO. Whenever the FIFO reports not-empty, the block issues a one-cycle read request and captures the 4-bit word on the following cycle. It then transmits the word on a single serial line as a UART-style frame: one start bit, four data bits LSB-first, one stop bit. At top level it owns the FIFO read side; `rd_req` drives the FIFO's `wnr` low through the top-level write/read mux, and read has priority there.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; legal range 1..256.
- `DATA_W`, default 4: word width; must match the FIFO width.

Ports (clock and reset first):
- `clk_d`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low: asserts immediately, releases synchronously to `clk_d`.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_d_out`  in  DATA_W  FIFO read data; valid the cycle after a read request.
- `rd_req`  out  1  one-cycle FIFO read request; active high.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse in the final stop-bit cycle.

## Operation
- Moore FSM with states IDLE, REQ, LOAD, START, DATA, STOP.
  - IDLE: if `fifo_empty`=0, go to REQ; otherwise stay.
  - REQ: `rd_req`=1 for exactly this one cycle; go to LOAD.
  - LOAD: capture `fifo_d_out` into the DATA_W shift register; clear the bit timer; go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles; go to DATA.
  - DATA: `tx`=shreg[0]. On each bit-timer expiry, shift right and increment the bit index. After DATA_W bits, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. `frame_done`=1 in the last cycle. Next state is REQ if `fifo_empty`=0, otherwise IDLE.
- Bit timer counts 0..CLKS_PER_BIT-1 and expires at CLKS_PER_BIT-1. Width is clog2(CLKS_PER_BIT), with a minimum of 1. The bit index is clog2(DATA_W) bits wide.
- `fifo_empty` is sampled only in IDLE and in the last STOP cycle. Changes during a frame are ignored.
- `tx`, `rd_req`, `busy` and `frame_done` are decoded from registered state only; no combinational path from inputs to outputs.

## Timing
- Reset values: state=IDLE, `tx`=1, `rd_req`=0, `busy`=0, `frame_done`=0, shift register=0, counters=0.
- Reset mid-frame: outputs take their reset values immediately (asynchronous). The word in flight is lost and no `frame_done` is generated.
- Start-up latency: IDLE sees `fifo_empty`=0 in cycle n. Then `rd_req`=1 in cycle n+1, LOAD in n+2, and `tx` falls in n+3.
- Frame length on `tx`: (DATA_W+2)·CLKS_PER_BIT cycles, i.e. 24 with defaults.
- Back-to-back words: STOP→REQ→LOAD adds 2 idle-high cycles between frames. Period is (DATA_W+2)·CLKS_PER_BIT+2 cycles (26 with defaults).
- CLKS_PER_BIT=1: each bit lasts one cycle and the timer is always expired. This configuration is legal.
- Exactly one `rd_req` per transmitted frame. `rd_req` is never asserted while `fifo_empty`=1 at the sample point.

## Structure
- Shared package `nibble_tx_pkg`:
  - state encoding constants: IDLE=0, REQ=1, LOAD=2, START=3, DATA=4, STOP=5, 3 bits;
  - FRAME_BITS = DATA_W+2;
  - a clog2 function.
- One sub-module, `bit_timer`. It is parameterised by CLKS_PER_BIT, has inputs `clr` and `en`, and output `tick`. It is reused later by the RX side.
- Top-level mux that turns `rd_req` into FIFO `wnr`: outside this block.

## Test plan
- Reset, then idle with `fifo_empty`=1 → `tx`=1, `busy`=0, `rd_req`=0 for 100 cycles.
- Single word 4'b1011, CLKS_PER_BIT=4 → `rd_req` pulses once. `tx` carries 0,1,1,0,1,1, each for 4 cycles. `frame_done` pulses once, 26 cycles after `fifo_empty` falls.
- FIFO preloaded with 1..8 and the real FIFO attached → eight frames with decoded nibbles 1..8 in order. Exactly 8 `rd_req` pulses, 26-cycle period, then IDLE.
- `rst` driven low mid-DATA → `tx`=1 and `busy`=0 in the same cycle, no `frame_done`. After release, the next word transmits correctly.
- CLKS_PER_BIT=1 with word 4'b0110 → `tx` = 0,0,1,1,0,1 on consecutive cycles, period 8.
- `fifo_empty` toggled during START/DATA → no extra `rd_req`, frame content unchanged.
